// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty bank: default width, channel-select width,
// reset duty spread across channels and the packed duty bus layout.
package pwm_pkg;

   localparam int DUTY_W_DEF = 8;

   function automatic int ch_w(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

   // D(i) = ((i+1) * 2^duty_w) / (num_ch+1): evenly spread defaults, none at 0 or full scale
   function automatic longint unsigned default_duty(input int i, input int num_ch, input int duty_w);
      longint unsigned full;
      full = longint'(1) << duty_w;
      return (longint'(i + 1) * full) / longint'(num_ch + 1);
   endfunction

   // Channel i occupies duty_out[duty_lsb(i) +: duty_w]
   function automatic int duty_lsb(input int ch, input int duty_w);
      return ch * duty_w;
   endfunction

endpackage

// File: rtl/pwm_duty_bank_if.sv
// Host-side register port and PWM-side duty outputs of the duty bank.
interface pwm_duty_bank_if import pwm_pkg::*; #(
   parameter int NUM_CH = 4,
   parameter int DUTY_W = DUTY_W_DEF
);
   localparam int CH_W = ch_w(NUM_CH);

   // All inputs are single-cycle strobes sampled every clk; there is no
   // backpressure, so a strobe high at a rising edge is always accepted.
   logic                     we;
   logic [CH_W-1:0]          ch_sel;
   logic [DUTY_W-1:0]        duty_in;
   logic                     commit;
   logic                     period_end;
   logic                     slew_en;
   logic [DUTY_W-1:0]        slew_step;
   logic [NUM_CH*DUTY_W-1:0] duty_out;
   logic                     pending;
   logic                     busy;
   logic                     wr_err;

   modport master (
      output we, ch_sel, duty_in, commit, period_end, slew_en, slew_step,
      input  duty_out, pending, busy, wr_err
   );

   modport slave (
      input  we, ch_sel, duty_in, commit, period_end, slew_en, slew_step,
      output duty_out, pending, busy, wr_err
   );

endinterface

// File: rtl/duty_slew_ch.sv
// One channel's target/active duty pair; active moves only on period_end,
// either loading the target directly or stepping toward it by at most slew_step.
module duty_slew_ch #(
   parameter int              DUTY_W  = 8,
   parameter logic [DUTY_W-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              period_end,
   input  logic              load,
   input  logic [DUTY_W-1:0] new_target,
   input  logic              slew_en,
   input  logic [DUTY_W-1:0] slew_step,
   output logic [DUTY_W-1:0] duty,
   output logic              at_target
);

   logic [DUTY_W-1:0] target;
   logic [DUTY_W-1:0] gap;
   logic [DUTY_W-1:0] step;
   logic              up;

   // Step is clipped to the remaining gap, so no wrap at either end of the range
   always_comb begin
      up   = target > duty;
      gap  = up ? (target - duty) : (duty - target);
      step = (slew_step < gap) ? slew_step : gap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target <= RST_VAL;
         duty   <= RST_VAL;
      end else if (period_end) begin
         if (load) target <= new_target;
         if (!slew_en)  duty <= load ? new_target : target;
         else if (up)   duty <= duty + step;
         else           duty <= duty - step;
      end
   end

   assign at_target = (duty == target);

endmodule

// File: rtl/pwm_duty_bank.sv
// Multi-channel double-buffered PWM duty bank: host writes shadow registers,
// a commit moves all shadows to the channel targets at the next period boundary.
module pwm_duty_bank import pwm_pkg::*; #(
   parameter int NUM_CH = 4,
   parameter int DUTY_W = DUTY_W_DEF
) (
   input logic             clk,
   input logic             rst,
   pwm_duty_bank_if.slave  bus
);

   localparam int CH_W = ch_w(NUM_CH);

   logic [DUTY_W-1:0]        shadow [NUM_CH];
   logic [NUM_CH*DUTY_W-1:0] duty_bus;
   logic [NUM_CH-1:0]        at_target;
   logic                     pending_q;
   logic                     wr_err_q;
   logic                     sel_ok;
   logic                     xfer;

   assign sel_ok = ({1'b0, bus.ch_sel} < (CH_W + 1)'(NUM_CH));
   // A commit on the boundary cycle itself transfers immediately
   assign xfer   = bus.period_end & (pending_q | bus.commit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++)
            shadow[i] <= DUTY_W'(default_duty(i, NUM_CH, DUTY_W));
      end else if (bus.we && sel_ok) begin
         shadow[bus.ch_sel] <= bus.duty_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         wr_err_q <= bus.we & ~sel_ok;
         if (xfer)            pending_q <= 1'b0;
         else if (bus.commit) pending_q <= 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      duty_slew_ch #(
         .DUTY_W  (DUTY_W),
         .RST_VAL (DUTY_W'(default_duty(g, NUM_CH, DUTY_W)))
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .period_end (bus.period_end),
         .load       (xfer),
         .new_target (shadow[g]),
         .slew_en    (bus.slew_en),
         .slew_step  (bus.slew_step),
         .duty       (duty_bus[duty_lsb(g, DUTY_W) +: DUTY_W]),
         .at_target  (at_target[g])
      );
   end

   assign bus.duty_out = duty_bus;
   assign bus.pending  = pending_q;
   assign bus.wr_err   = wr_err_q;
   assign bus.busy     = pending_q | ~(&at_target);

endmodule

// File: tb/tb_pwm_duty_bank.sv
// Bench for pwm_duty_bank: randomized and directed host traffic, a per-channel
// arithmetic model, and a monitor that checks every post-edge output snapshot.
module tb_pwm_duty_bank;

   localparam int NUM_CH = 5;
   localparam int DUTY_W = 8;
   localparam int CH_W   = 3;
   localparam int W      = NUM_CH * DUTY_W + 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pwm_duty_bank_if #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W)) bus ();

   pwm_duty_bank #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   // Reference model state, plain integers per channel
   int shadow_m [NUM_CH];
   int target_m [NUM_CH];
   int duty_m   [NUM_CH];
   bit pending_m;
   bit wr_err_m;
   bit sen;
   int sstep;

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [W-1:0] snap();
      logic [W-1:0] s;
      bit busy_m;
      s = '0;
      busy_m = pending_m;
      for (int i = 0; i < NUM_CH; i++) begin
         s[i*DUTY_W +: DUTY_W] = DUTY_W'(duty_m[i]);
         if (duty_m[i] != target_m[i]) busy_m = 1'b1;
      end
      s[W-1 -: 3] = {wr_err_m, busy_m, pending_m};
      return s;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         shadow_m[i] = ((i + 1) * (1 << DUTY_W)) / (NUM_CH + 1);
         target_m[i] = shadow_m[i];
         duty_m[i]   = shadow_m[i];
      end
      pending_m = 1'b0;
      wr_err_m  = 1'b0;
   endfunction

   function automatic void model_step(input bit we_v, input int sel_v, input int din_v,
                                      input bit commit_v, input bit pe_v);
      bit xfer;
      xfer = pe_v && (pending_m || commit_v);
      if (pe_v) begin
         for (int i = 0; i < NUM_CH; i++) begin
            int old_t;
            old_t = target_m[i];
            if (xfer) target_m[i] = shadow_m[i];
            if (!sen)                    duty_m[i] = target_m[i];
            else if (old_t > duty_m[i])  duty_m[i] = duty_m[i] + min_i(sstep, old_t - duty_m[i]);
            else                         duty_m[i] = duty_m[i] - min_i(sstep, duty_m[i] - old_t);
         end
      end
      pending_m = xfer ? 1'b0 : (pending_m || commit_v);
      wr_err_m  = we_v && (sel_v >= NUM_CH);
      if (we_v && sel_v < NUM_CH) shadow_m[sel_v] = din_v;
   endfunction

   task automatic drive(input bit we_v, input int sel_v, input int din_v,
                        input bit commit_v, input bit pe_v);
      @(negedge clk);
      bus.we         = we_v;
      bus.ch_sel     = CH_W'(sel_v);
      bus.duty_in    = DUTY_W'(din_v);
      bus.commit     = commit_v;
      bus.period_end = pe_v;
      bus.slew_en    = sen;
      bus.slew_step  = DUTY_W'(sstep);
      model_step(we_v, sel_v, din_v, commit_v, pe_v);
      exp_q.push_back(snap());
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic boundary();
      drive(1'b0, 0, 0, 1'b0, 1'b1);
   endtask

   // Reset is raised and dropped between clock edges to exercise the async path
   task automatic do_reset();
      @(negedge clk);
      bus.we = 1'b0; bus.commit = 1'b0; bus.period_end = 1'b0;
      bus.ch_sel = '0; bus.duty_in = '0;
      model_reset();
      exp_q.push_back(snap());
      #1 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   // Monitor: one snapshot per clock edge (or reset assertion) while traffic is queued
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (bus.duty_out !== e[NUM_CH*DUTY_W-1:0]) begin
               bad++;
               $display("FAIL duty_out t=%0t got=%h exp=%h", $time, bus.duty_out,
                        e[NUM_CH*DUTY_W-1:0]);
            end
            total++;
            if ({bus.wr_err, bus.busy, bus.pending} !== e[W-1 -: 3]) begin
               bad++;
               $display("FAIL flags(wr_err,busy,pending) t=%0t got=%b exp=%b", $time,
                        {bus.wr_err, bus.busy, bus.pending}, e[W-1 -: 3]);
            end
         end
      end
   end

   initial begin
      bus.we = 1'b0; bus.ch_sel = '0; bus.duty_in = '0; bus.commit = 1'b0;
      bus.period_end = 1'b0; bus.slew_en = 1'b0; bus.slew_step = '0;
      sen = 1'b0; sstep = 0;
      do_reset();

      // Uncommitted write stays invisible across boundaries, then a commit lands it
      drive(1'b1, 1, 200, 1'b0, 1'b0);
      repeat (3) begin idle(); boundary(); end
      drive(1'b0, 0, 0, 1'b1, 1'b0);
      idle();
      boundary();
      idle();

      // Write, commit and boundary in one cycle: transfer uses the older shadow
      drive(1'b1, 0, 10, 1'b1, 1'b1);
      idle();
      drive(1'b0, 0, 0, 1'b1, 1'b1);
      idle();

      // Ramp channel 2 down to 20 in steps of 16
      sen = 1'b1; sstep = 16;
      drive(1'b1, 2, 20, 1'b0, 0);
      drive(1'b0, 0, 0, 1'b1, 1'b0);
      boundary();
      repeat (9) begin idle(); boundary(); end

      // Out-of-range channel selects
      drive(1'b1, 6, 99, 1'b0, 1'b0);
      idle();
      drive(1'b1, 5, 77, 1'b0, 1'b0);
      drive(1'b1, 7, 1, 1'b0, 1'b0);
      idle();

      // Ramp up, then leave ramp mode mid-ramp to snap; step 0 freezes
      drive(1'b1, 3, 250, 1'b1, 1'b0);
      boundary(); boundary(); boundary();
      sstep = 0; boundary();
      sen = 1'b0; boundary();
      idle();

      // Reset mid-ramp with a commit pending
      sen = 1'b1; sstep = 3;
      drive(1'b1, 0, 255, 1'b1, 1'b0);
      boundary(); boundary(); boundary();
      drive(1'b1, 4, 0, 1'b1, 1'b0);
      idle();
      do_reset();
      idle();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 15) == 0) sen = ~sen;
         if ($urandom_range(0, 7) == 0)  sstep = $urandom_range(0, 40);
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 255),
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d exp=0 (snapshots left unchecked)", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
